token_packet_rx: RTL

//  Receive-side packet parser between the PHY byte interface and link_control.

---
 rtl/usb_pkg.sv | 37 +++
 rtl/token_packet_rx_if.sv | 12 +
 rtl/usb_crc5.sv | 23 ++
 rtl/token_packet_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - PID codes, CRC5 constants and parser state type
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // x^5 + x^2 + 1, the x^5 term is implicit in the shift
  localparam logic [4:0] CRC5_POLY = 5'b00101;
  localparam logic [4:0] CRC5_INIT = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TOK1,
    ST_TOK2,
    ST_WAIT_EOP
  } rx_state_e;

  function automatic logic is_token(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

  function automatic logic is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic logic is_handshake(input logic [3:0] p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
  endfunction

endpackage

// File: rtl/token_packet_rx_if.sv
// rtl/token_packet_rx_if.sv - PHY receive byte stream into the packet parser
interface token_packet_rx_if;

  logic [7:0] rx_data_in;
  logic       rx_valid_in;
  logic       rx_sop_in;
  logic       rx_eop_in;

  modport master (output rx_data_in, rx_valid_in, rx_sop_in, rx_eop_in);
  modport slave  (input  rx_data_in, rx_valid_in, rx_sop_in, rx_eop_in);

endinterface

// File: rtl/usb_crc5.sv
// rtl/usb_crc5.sv - combinational token CRC5, returns the inverted remainder
module usb_crc5
  import usb_pkg::*;
(
  input  logic [10:0] data,
  output logic [4:0]  crc
);

  logic [4:0] rem;
  logic       fb;

  // Bit-serial LFSR unrolled over 11 bits, data[0] first as on the wire
  always_comb begin
    rem = CRC5_INIT;
    fb  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb  = rem[4] ^ data[i];
      rem = {rem[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
    crc = ~rem;
  end

endmodule

// File: rtl/token_packet_rx.sv
// rtl/token_packet_rx.sv - receive packet parser: PID check, token decode, CRC5, address filter
module token_packet_rx
  import usb_pkg::*;
#(
  parameter bit ADDR_CHK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  token_packet_rx_if.slave      phy,
  input  logic [6:0]            dev_addr,
  input  logic                  rx_handshake_on,
  output logic                  rx_sop,
  output logic                  rx_eop,
  output logic [3:0]            rx_pid,
  output logic                  rx_pid_en,
  output logic [6:0]            rx_addr,
  output logic [3:0]            rx_endp,
  output logic                  pid_err,
  output logic                  crc5_err,
  output logic                  len_err
);

  rx_state_e  state, state_d;
  logic [3:0] tok_pid, tok_pid_d;
  logic [6:0] tok_addr, tok_addr_d;
  logic       tok_endp0, tok_endp0_d;

  logic       sop_d, eop_d, pid_en_d, pid_err_d, crc5_err_d, len_err_d;
  logic [3:0] pid_d;
  logic [6:0] addr_d;
  logic [3:0] endp_d;

  logic [7:0] b;
  logic [3:0] pid;
  logic       pid_ok;
  logic       eop;
  logic [3:0] endp_full;
  logic [4:0] crc_calc;
  logic       crc_ok;
  logic       addr_ok;

  assign b         = phy.rx_data_in;
  assign pid       = b[3:0];
  assign pid_ok    = (b[7:4] == ~b[3:0]);
  assign eop       = phy.rx_eop_in;
  assign endp_full = {b[2:0], tok_endp0};
  assign crc_ok    = (crc_calc == b[7:3]);
  // SOF carries a frame number in the address field, so it is never filtered
  assign addr_ok   = !ADDR_CHK || (tok_addr == dev_addr) || (tok_pid == PID_SOF);

  usb_crc5 u_crc5 (
    .data ({endp_full, tok_addr}),
    .crc  (crc_calc)
  );

  // State and token capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tok_pid   <= 4'h0;
      tok_addr  <= 7'h00;
      tok_endp0 <= 1'b0;
    end else begin
      state     <= state_d;
      tok_pid   <= tok_pid_d;
      tok_addr  <= tok_addr_d;
      tok_endp0 <= tok_endp0_d;
    end
  end

  // Next state and next output values; everything is evaluated only on valid beats
  always_comb begin
    state_d     = state;
    tok_pid_d   = tok_pid;
    tok_addr_d  = tok_addr;
    tok_endp0_d = tok_endp0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    pid_en_d    = 1'b0;
    pid_err_d   = 1'b0;
    crc5_err_d  = 1'b0;
    len_err_d   = 1'b0;
    pid_d       = rx_pid;
    addr_d      = rx_addr;
    endp_d      = rx_endp;

    if (phy.rx_valid_in) begin
      if (phy.rx_sop_in) begin
        // A new packet always restarts the parse; a cut-off token is a length error
        if (state == ST_TOK1 || state == ST_TOK2) len_err_d = 1'b1;
        sop_d = 1'b1;
        if (!pid_ok || !(is_token(pid) || is_data(pid) || is_handshake(pid))) begin
          pid_err_d = 1'b1;
          if (eop) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_EOP;
          end
        end else if (is_token(pid)) begin
          if (eop) begin
            len_err_d = 1'b1;
            eop_d     = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tok_pid_d = pid;
            state_d   = ST_TOK1;
          end
        end else if (is_data(pid)) begin
          pid_d    = pid;
          pid_en_d = 1'b1;
          if (eop) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_EOP;
          end
        end else begin
          if (!eop) begin
            len_err_d = 1'b1;
            state_d   = ST_WAIT_EOP;
          end else begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
            if (rx_handshake_on) begin
              pid_d    = pid;
              pid_en_d = 1'b1;
            end
          end
        end
      end else begin
        case (state)
          ST_TOK1: begin
            if (eop) begin
              len_err_d = 1'b1;
              eop_d     = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              tok_addr_d  = b[6:0];
              tok_endp0_d = b[7];
              state_d     = ST_TOK2;
            end
          end
          ST_TOK2: begin
            if (!eop) begin
              len_err_d = 1'b1;
              state_d   = ST_WAIT_EOP;
            end else begin
              eop_d   = 1'b1;
              state_d = ST_IDLE;
              if (!crc_ok) begin
                crc5_err_d = 1'b1;
              end else if (addr_ok) begin
                // link_control latches rx_eop on rx_pid_en, so both pulse together
                pid_d    = tok_pid;
                addr_d   = tok_addr;
                endp_d   = endp_full;
                pid_en_d = 1'b1;
              end
            end
          end
          ST_WAIT_EOP: begin
            if (eop) begin
              eop_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs, one cycle after the causing beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sop    <= 1'b0;
      rx_eop    <= 1'b0;
      rx_pid    <= 4'h0;
      rx_pid_en <= 1'b0;
      rx_addr   <= 7'h00;
      rx_endp   <= 4'h0;
      pid_err   <= 1'b0;
      crc5_err  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      rx_sop    <= sop_d;
      rx_eop    <= eop_d;
      rx_pid    <= pid_d;
      rx_pid_en <= pid_en_d;
      rx_addr   <= addr_d;
      rx_endp   <= endp_d;
      pid_err   <= pid_err_d;
      crc5_err  <= crc5_err_d;
      len_err   <= len_err_d;
    end
  end

endmodule
